// File: rtl/pwm_pkg.sv
// pwm_pkg: brightness level definitions shared by the PWM generator and capture.
package pwm_pkg;

    localparam int LEVEL_W    = 4;
    localparam int NUM_LEVELS = 5;

    // Thresholds sit at the midpoints between adjacent duty levels.
    localparam int DUTY_PCT   [NUM_LEVELS]   = '{5, 25, 50, 75, 100};
    localparam int THRESH_PCT [NUM_LEVELS-1] = '{15, 38, 63, 88};

    typedef enum logic [1:0] {ARM, MEAS, STUCK} cap_state_t;

endpackage

// File: rtl/pwm_capture_sync_rise.sv
// sync_rise: multi-flop synchroniser for an asynchronous input plus rising-edge detect.
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= o_s;
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM input, quantises
// the duty cycle to the generator's 0..4 level scale and flags stuck inputs.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = 2000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pwm_in,
    output logic [CNT_W-1:0]   period_out,
    output logic [CNT_W-1:0]   high_out,
    output logic [LEVEL_W-1:0] level_out,
    output logic               stuck_hi,
    output logic               stuck_lo,
    output logic               valid
);

    localparam int              PW = CNT_W + 7;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    logic               w_s;
    logic               w_rise;
    logic               w_at_to;
    logic [PW-1:0]      w_d;
    logic [LEVEL_W-1:0] w_level;
    logic [CNT_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]   r_hcnt;
    cap_state_t         r_state;

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .i_d    (pwm_in),
        .o_s    (w_s),
        .o_rise (w_rise)
    );

    assign w_at_to = r_pcnt == TO;

    // Level = number of thresholds the duty cycle reaches; full-width products, no truncation.
    always_comb begin
        w_d     = PW'(r_hcnt) * PW'(100);
        w_level = '0;
        for (int i = 0; i < NUM_LEVELS - 1; i++)
            w_level = w_level + LEVEL_W'(w_d >= PW'(r_pcnt) * PW'(THRESH_PCT[i]));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ARM;
            r_pcnt     <= '0;
            r_hcnt     <= '0;
            period_out <= '0;
            high_out   <= '0;
            level_out  <= '0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_rise) begin
                r_pcnt  <= CNT_W'(1);
                r_hcnt  <= CNT_W'(1);
                r_state <= MEAS;
                if (r_state == MEAS) begin
                    period_out <= r_pcnt;
                    high_out   <= r_hcnt;
                    level_out  <= w_level;
                    stuck_hi   <= 1'b0;
                    stuck_lo   <= 1'b0;
                    valid      <= 1'b1;
                end
            end else if (!w_at_to) begin
                r_pcnt <= r_pcnt + CNT_W'(1);
                r_hcnt <= r_hcnt + CNT_W'(w_s);
            end else if (r_state != STUCK) begin
                // pcnt stays parked at TIMEOUT, so STUCK reports exactly once.
                r_state    <= STUCK;
                period_out <= '0;
                high_out   <= '0;
                level_out  <= w_s ? LEVEL_W'(4) : '0;
                stuck_hi   <= w_s;
                stuck_lo   <= ~w_s;
                valid      <= 1'b1;
            end
        end
    end

endmodule
